// File: rtl/adc_tx_emulator.sv
// Transmit-side emulator for the 2-lane, byte-wise, 16-bit LVDS ADC link.
// Serialises one word per 8-slot frame and produces FCO/DCO alongside the lane bits.
module adc_tx_emulator #(
  parameter logic [15:0] RAMP_STEP     = 16'd1,
  parameter logic [15:0] FIXED_PATTERN = 16'hA5C3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [2:0]  fco_phase,
  input  logic        underrun_clr,
  output logic        dco,
  output logic        fco,
  output logic        ln1,
  output logic        ln0,
  output logic        frame_start,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_FIXED  = 2'd2,
    MODE_CHECK  = 2'd3
  } mode_e;

  logic [2:0]  k;
  logic [15:0] word;
  logic [2:0]  phase_l;
  logic [15:0] hold_reg;
  logic        hold_full;
  logic [15:0] ramp;
  logic        cb_odd;

  logic        load, accept, bypass, set_ur;
  logic [15:0] src_word, cur_word;
  logic [2:0]  cur_phase, fco_d;
  logic [7:0]  hi_byte, lo_byte;

  assign s_ready = en && (mode == MODE_STREAM) && !hold_full;
  assign accept  = s_valid && s_ready;
  assign load    = en && (k == 3'd0);
  // An empty register at the load slot lets a same-cycle sample go straight into the frame.
  assign bypass  = load && (mode == MODE_STREAM) && !hold_full && accept;

  always_comb begin
    src_word = 16'h0000;
    set_ur   = 1'b0;
    case (mode_e'(mode))
      MODE_STREAM: begin
        if (hold_full)   src_word = hold_reg;
        else if (accept) src_word = s_data;
        else             set_ur   = 1'b1;
      end
      MODE_RAMP:  src_word = ramp;
      MODE_FIXED: src_word = FIXED_PATTERN;
      MODE_CHECK: src_word = cb_odd ? 16'h5555 : 16'hAAAA;
      default:    src_word = 16'h0000;
    endcase
  end

  assign cur_word  = load ? src_word : word;
  assign cur_phase = load ? fco_phase : phase_l;
  assign fco_d     = k - cur_phase;
  assign hi_byte   = cur_word[15:8];
  assign lo_byte   = cur_word[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      word        <= '0;
      phase_l     <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      ramp        <= '0;
      cb_odd      <= 1'b0;
      dco         <= 1'b0;
      fco         <= 1'b0;
      ln1         <= 1'b0;
      ln0         <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (accept && !bypass) begin
        hold_reg  <= s_data;
        hold_full <= 1'b1;
      end
      if (load && set_ur)     underrun <= 1'b1;
      else if (underrun_clr)  underrun <= 1'b0;

      if (!en) begin
        // Abandon the partial frame; pattern state, count and holding register stay put.
        k           <= '0;
        dco         <= 1'b0;
        fco         <= 1'b0;
        ln1         <= 1'b0;
        ln0         <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        k           <= k + 3'd1;
        ln1         <= hi_byte[3'd7 - k];
        ln0         <= lo_byte[3'd7 - k];
        fco         <= ~fco_d[2];
        dco         <= ~k[0];
        frame_start <= load;
        if (load) begin
          word      <= src_word;
          phase_l   <= fco_phase;
          frame_cnt <= frame_cnt + 16'd1;
          if (mode == MODE_STREAM && hold_full) hold_full <= 1'b0;
          if (mode == MODE_RAMP)  ramp   <= ramp + RAMP_STEP;
          if (mode == MODE_CHECK) cb_odd <= ~cb_odd;
        end
      end
    end
  end

endmodule
